axis_1553_encoder_gen: RTL and testbench
========================================

// Module: axis_1553_encoder_gen
// PURPOSE
//  Synthesizable MIL-STD-1553 word transmitter with fault injection. Takes 16-bit words on an
//  AXI-Stream slave and drives Manchester-II differential output for axis_1553_decoder.
//  Serves as a loop-back source and as the transmit side of the core. Adds per-word sync
//  selection, programmable inter-word gap, and parity/sync/Manchester error injection.
// PARAMETERS
//  CLOCK_SPEED  100000000  aclk frequency in Hz; integer multiple of 2000000 and >= 2000000
//  DELAY_BITS   0          idle gap after each word, in 1 us bit times (0..255)
//  IDLE_STATE   2'b00      diff value while idle, during gap, and in reset
// PORTS
//  aclk           in   1   clock
//  arstn          in   1   asynchronous active-low reset
//  s_axis_tdata   in   16  word payload, sent MSB first
//  s_axis_tuser   in   8   [0] sync: 1=cmd/status, 0=data; [1] flip parity; [2] sync fault;
//                          [3] Manchester fault enable; [7:4] faulted bit index (0 = tdata[15])
//  s_axis_tvalid  in   1   word valid
//  s_axis_tready  out  1   word accepted when tvalid & tready on a rising aclk edge
//  diff           out  2   diff[0] line +, diff[1] line -; diff[1] = ~diff[0] while transmitting
//  busy           out  1   high from accept until the last gap cycle
// BEHAVIOUR
//  - Reset (async, immediate): diff=IDLE_STATE, s_axis_tready=0, busy=0, state=IDLE.
//    s_axis_tready goes to 1 on the first clock after arstn deasserts.
//  - HALF = CLOCK_SPEED/2000000 clocks per half bit. A word is 40 half bits = 20*2*HALF clocks.
//  - Accept in IDLE. tdata and tuser are latched. The first sync sample appears on diff on the
//    next clock (latency 1).
//  - FSM: IDLE -> SYNC (6 half bits) -> DATA (32) -> PARITY (2) -> GAP (2*DELAY_BITS) -> IDLE.
//    GAP is skipped when DELAY_BITS=0.
//  - diff[0] encoding, matching the decoder:
//    - data 1 = low then high; data 0 = high then low.
//    - cmd/status sync = 3 half bits low, then 3 high. Data sync = 3 high, then 3 low.
//  - Parity is odd: p = ~^tdata. tuser[1] sends ~p.
//  - tuser[2]: the whole sync holds the level of its first half (no mid-sync transition).
//  - tuser[3]: the bit at index tuser[7:4] repeats its first-half level in its second half.
//  - Back-to-back words (DELAY_BITS=0 only):
//    - s_axis_tready=1 on the last clock of the parity second half.
//    - If a word is accepted there, SYNC starts on the next clock with no idle sample.
//    - Otherwise the FSM enters IDLE with diff=IDLE_STATE.
//  - With DELAY_BITS>0, s_axis_tready is 0 throughout SYNC, DATA, PARITY and GAP.
//  - tvalid high while tready is 0 is ignored. tdata/tuser changes mid-word have no effect.
//  - Half-bit counter and half-bit index reload on every state entry, so no wrap drift.
//  - busy=1 from the accept clock through the final GAP clock. For back-to-back words busy
//    stays high across words.
//  - Elaboration: CLOCK_SPEED % 2000000 != 0, or DELAY_BITS > 255 -> $error.
// STRUCTURE
//  - 1553_defines.vh (shared with decoder): tuser bit positions, sync patterns, FSM state
//    encodings, half-bit counts (SYNC_HB=6, DATA_HB=32, PAR_HB=2).
//  - Sub-module pulse_gen_1553: free-running divide-by-HALF tick with synchronous restart.
//  - Top level holds the FSM, 20-bit shift register {sync, data, parity}, and fault masks.
//  - Target size 150-300 lines.
// TESTING  (CLOCK_SPEED=100 MHz, HALF=50, DELAY_BITS=0 unless noted; diff[0] listed)
//  1. tdata=16'hFFFF, tuser=8'h01 -> 150 clk low, 150 high, then 16 x (50 low/50 high),
//     parity 1 (50 low/50 high); 2000 clk total; then IDLE 2'b00.
//  2. tdata=16'h0000, tuser=8'h00 -> 150 high, 150 low, 16 x (50 high/50 low),
//     parity 1 (low/high).
//  3. tdata=16'h0001, tuser=8'h03 -> parity sent 1 (low/high) instead of 0. The decoder
//     flags a parity error.
//  4. tdata=16'hA5A5, tuser=8'h59 -> bit 5 (tdata[10]=1) is 100 clk low. Sync/other bits
//     correct. Separately tuser=8'h05 -> sync is 300 clk low.
//  5. Two beats, tvalid held high, DELAY_BITS=0 -> second sync starts the clock after the
//     first parity ends; 4000 clk contiguous; busy never drops.
//     With DELAY_BITS=4: 400 clk of IDLE_STATE between words.
//  6. arstn low at clk 700 of a word -> diff=2'b00 and tready=0 immediately. After release:
//     tready=1 next clock; a new word is transmitted correctly.

Source files
------------

// File: rtl/axis_1553_encoder_gen_pkg.sv
// Shared constants for the MIL-STD-1553 word transmitter: half-bit counts,
// tuser field positions and FSM state encoding.
package axis_1553_encoder_gen_pkg;

  localparam int HB_RATE = 2000000;
  localparam int SYNC_HB = 6;
  localparam int DATA_HB = 32;
  localparam int PAR_HB  = 2;

  localparam int TU_SYNC    = 0;
  localparam int TU_PFLIP   = 1;
  localparam int TU_SFAULT  = 2;
  localparam int TU_MFAULT  = 3;
  localparam int TU_IDX_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_GAP
  } state_t;

endpackage

// File: rtl/axis_1553_encoder_gen_pulse_gen.sv
// Free-running divide-by-HALF tick; restart realigns the tick to a state entry
// so half-bit boundaries never drift relative to the FSM.
module pulse_gen_1553 #(
  parameter int HALF = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (restart || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/axis_1553_encoder_gen.sv
// MIL-STD-1553 word transmitter: AXI-Stream word in, Manchester-II differential
// out, with per-word sync type, optional inter-word gap and fault injection.
module axis_1553_encoder_gen #(
  parameter int         CLOCK_SPEED = 100000000,
  parameter int         DELAY_BITS  = 0,
  parameter logic [1:0] IDLE_STATE  = 2'b00
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [15:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  diff,
  output logic        busy
);

  import axis_1553_encoder_gen_pkg::*;

  localparam int         HALF   = CLOCK_SPEED / HB_RATE;
  localparam logic [8:0] GAP_HB = 9'(2 * DELAY_BITS);

  if (CLOCK_SPEED < HB_RATE || (CLOCK_SPEED % HB_RATE) != 0 ||
      DELAY_BITS < 0 || DELAY_BITS > 255) begin : g_param_check
    $error("axis_1553_encoder_gen: illegal CLOCK_SPEED or DELAY_BITS");
  end

  state_t      state, next_state;
  logic [8:0]  hb_idx;
  logic [15:0] data_q;
  logic        par_q, cmd_q, sync_flt_q, man_flt_q, ready_en;
  logic [3:0]  flt_idx_q, bit_idx;
  logic        tick, last_hb, state_done, accept, restart, d0, tx_on;

  pulse_gen_1553 #(.HALF(HALF)) u_pulse (
    .clk    (aclk),
    .rst_n  (arstn),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    last_hb = 1'b0;
    case (state)
      ST_SYNC:   last_hb = (hb_idx == 9'(SYNC_HB - 1));
      ST_DATA:   last_hb = (hb_idx == 9'(DATA_HB - 1));
      ST_PARITY: last_hb = (hb_idx == 9'(PAR_HB - 1));
      ST_GAP:    last_hb = (hb_idx == GAP_HB - 9'd1);
      default:   last_hb = 1'b0;
    endcase
  end

  // Back-to-back acceptance is only possible on the final parity clock, and only without a gap.
  assign state_done    = tick & last_hb;
  assign s_axis_tready = ready_en & ((state == ST_IDLE) |
                         ((DELAY_BITS == 0) & (state == ST_PARITY) & state_done));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign restart       = accept | (next_state != state);

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state      <= ST_IDLE;
      hb_idx     <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      cmd_q      <= 1'b0;
      sync_flt_q <= 1'b0;
      man_flt_q  <= 1'b0;
      flt_idx_q  <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      state    <= next_state;
      if (restart)
        hb_idx <= '0;
      else if (tick && state != ST_IDLE)
        hb_idx <= hb_idx + 9'd1;
      if (accept) begin
        data_q     <= s_axis_tdata;
        par_q      <= (~^s_axis_tdata) ^ s_axis_tuser[TU_PFLIP];
        cmd_q      <= s_axis_tuser[TU_SYNC];
        sync_flt_q <= s_axis_tuser[TU_SFAULT];
        man_flt_q  <= s_axis_tuser[TU_MFAULT];
        flt_idx_q  <= s_axis_tuser[TU_IDX_LSB +: 4];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_SYNC;
      ST_SYNC:   if (state_done) next_state = ST_DATA;
      ST_DATA:   if (state_done) next_state = ST_PARITY;
      ST_PARITY: begin
        if (state_done) begin
          if (accept)
            next_state = ST_SYNC;
          else if (GAP_HB != 9'd0)
            next_state = ST_GAP;
          else
            next_state = ST_IDLE;
        end
      end
      ST_GAP:    if (state_done) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // diff[0] level: a faulted half repeats the level of the half before it.
  always_comb begin
    d0      = 1'b0;
    tx_on   = 1'b1;
    bit_idx = hb_idx[4:1];
    case (state)
      ST_SYNC:   d0 = (hb_idx < 9'd3 || sync_flt_q) ? ~cmd_q : cmd_q;
      ST_DATA: begin
        d0 = data_q[4'd15 - bit_idx];
        if (!hb_idx[0] || (man_flt_q && flt_idx_q == bit_idx))
          d0 = ~d0;
      end
      ST_PARITY: d0 = hb_idx[0] ? par_q : ~par_q;
      default:   tx_on = 1'b0;
    endcase
    diff = tx_on ? {~d0, d0} : IDLE_STATE;
    busy = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_axis_1553_encoder_gen.sv
// Bench for axis_1553_encoder_gen: two instances (no gap / 4-bit gap) checked every
// cycle against a half-bit waveform model, plus literal waveform and length checks.
module tb_axis_1553_encoder_gen;

  localparam int         CS    = 100000000;
  localparam int         HALF  = CS / 2000000;
  localparam int         D0    = 0;
  localparam int         D1    = 4;
  localparam logic [1:0] IDLE0 = 2'b00;
  localparam logic [1:0] IDLE1 = 2'b11;

  logic        clk;
  logic        arstn0, arstn1;
  logic [15:0] tdata0, tdata1;
  logic [7:0]  tuser0, tuser1;
  logic        tvalid0, tvalid1, tready0, tready1, busy0, busy1;
  logic [1:0]  diff0, diff1;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  bit         rdy0 = 1'b0;
  bit         rdy1 = 1'b0;

  axis_1553_encoder_gen #(.CLOCK_SPEED(CS), .DELAY_BITS(D0), .IDLE_STATE(IDLE0)) dut0 (
    .aclk(clk), .arstn(arstn0), .s_axis_tdata(tdata0), .s_axis_tuser(tuser0),
    .s_axis_tvalid(tvalid0), .s_axis_tready(tready0), .diff(diff0), .busy(busy0)
  );

  axis_1553_encoder_gen #(.CLOCK_SPEED(CS), .DELAY_BITS(D1), .IDLE_STATE(IDLE1)) dut1 (
    .aclk(clk), .arstn(arstn1), .s_axis_tdata(tdata1), .s_axis_tuser(tuser1),
    .s_axis_tvalid(tvalid1), .s_axis_tready(tready1), .diff(diff1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // diff[0] level for each of the 40 half bits of a word, first half bit in [39].
  function automatic logic [39:0] halfLevels(input logic [15:0] d, input logic [7:0] u);
    logic [39:0] hl;
    logic        p;
    hl = '0;
    for (int k = 0; k < 6; k++)
      hl[39-k] = u[0] ? (k >= 3) : (k < 3);
    if (u[2])
      for (int k = 0; k < 6; k++) hl[39-k] = hl[39];
    for (int b = 0; b < 16; b++) begin
      hl[33-2*b] = ~d[15-b];
      hl[32-2*b] = (u[3] && u[7:4] == 4'(b)) ? ~d[15-b] : d[15-b];
    end
    p     = (~^d) ^ u[1];
    hl[1] = ~p;
    hl[0] = p;
    return hl;
  endfunction

  always @(negedge clk) begin : model0
    logic [1:0]  ediff;
    logic        erdy;
    logic [39:0] hl;
    if (!arstn0) begin
      q0.delete();
      rdy0 = 1'b0;
    end
    erdy  = rdy0 && (q0.size() == 0 || (D0 == 0 && q0.size() == 1));
    ediff = (q0.size() != 0) ? q0[0] : IDLE0;
    checkOutput("dut0_diff",   64'(diff0),   64'(ediff));
    checkOutput("dut0_busy",   64'(busy0),   64'(q0.size() != 0));
    checkOutput("dut0_tready", 64'(tready0), 64'(erdy));
    if (arstn0) begin
      if (q0.size() != 0) void'(q0.pop_front());
      if (tvalid0 && erdy) begin
        hl = halfLevels(tdata0, tuser0);
        for (int h = 39; h >= 0; h--)
          for (int c = 0; c < HALF; c++) q0.push_back({~hl[h], hl[h]});
        for (int g = 0; g < 2 * D0 * HALF; g++) q0.push_back(IDLE0);
      end
      rdy0 = 1'b1;
    end
  end

  always @(negedge clk) begin : model1
    logic [1:0]  ediff;
    logic        erdy;
    logic [39:0] hl;
    if (!arstn1) begin
      q1.delete();
      rdy1 = 1'b0;
    end
    erdy  = rdy1 && (q1.size() == 0 || (D1 == 0 && q1.size() == 1));
    ediff = (q1.size() != 0) ? q1[0] : IDLE1;
    checkOutput("dut1_diff",   64'(diff1),   64'(ediff));
    checkOutput("dut1_busy",   64'(busy1),   64'(q1.size() != 0));
    checkOutput("dut1_tready", 64'(tready1), 64'(erdy));
    if (arstn1) begin
      if (q1.size() != 0) void'(q1.pop_front());
      if (tvalid1 && erdy) begin
        hl = halfLevels(tdata1, tuser1);
        for (int h = 39; h >= 0; h--)
          for (int c = 0; c < HALF; c++) q1.push_back({~hl[h], hl[h]});
        for (int g = 0; g < 2 * D1 * HALF; g++) q1.push_back(IDLE1);
      end
      rdy1 = 1'b1;
    end
  end

  // Holds tvalid until a handshake, then scrambles the inputs to show they are latched.
  task automatic applyStimulus(input int which, input logic [15:0] d, input logic [7:0] u);
    int n   = 0;
    bit got = 1'b0;
    if (which == 0) begin tdata0 = d; tuser0 = u; tvalid0 = 1'b1; end
    else            begin tdata1 = d; tuser1 = u; tvalid1 = 1'b1; end
    while (!got && n < 10000) begin
      @(negedge clk);
      got = (which == 0) ? tready0 : tready1;
      n++;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL handshake_timeout: dut%0d tready stayed 0 for %0d cycles", which, n);
    end
    @(posedge clk);
    #1;
    if (which == 0) begin tvalid0 = 1'b0; tdata0 = 16'($urandom); tuser0 = 8'($urandom); end
    else            begin tvalid1 = 1'b0; tdata1 = 16'($urandom); tuser1 = 8'($urandom); end
  endtask

  task automatic measureBusy(input int which, output int n, output int idle_n);
    bit b = 1'b1;
    n      = 0;
    idle_n = 0;
    while (b && n < 20000) begin
      @(negedge clk);
      b = (which == 0) ? busy0 : busy1;
      if (b) begin
        n++;
        if (which == 1 && diff1 == IDLE1) idle_n++;
      end
    end
  endtask

  initial begin
    int n, idle_n;
    tvalid0 = 1'b0; tvalid1 = 1'b0;
    tdata0  = '0;   tdata1  = '0;
    tuser0  = '0;   tuser1  = '0;
    arstn0  = 1'b1; arstn1  = 1'b1;
    #1;
    arstn0 = 1'b0;
    arstn1 = 1'b0;

    checkOutput("pin_ffff_cmd",  64'(halfLevels(16'hFFFF, 8'h01)), 64'h1D55555555);
    checkOutput("pin_0000_data", 64'(halfLevels(16'h0000, 8'h00)), 64'hE2AAAAAAA9);
    checkOutput("pin_pflip",     64'(halfLevels(16'h0001, 8'h03)), 64'h1EAAAAAAA5);
    checkOutput("pin_manfault",  64'(halfLevels(16'hA5A5, 8'h59)), 64'h1D9A259A65);
    checkOutput("pin_syncfault", 64'(halfLevels(16'hA5A5, 8'h05) >> 34), 64'h0);

    @(negedge clk);
    checkOutput("reset_diff0",   64'(diff0),   64'(2'b00));
    checkOutput("reset_diff1",   64'(diff1),   64'(2'b11));
    checkOutput("reset_tready0", 64'(tready0), 64'h0);
    checkOutput("reset_busy0",   64'(busy0),   64'h0);
    repeat (2) @(posedge clk);
    #1;
    arstn0 = 1'b1;
    arstn1 = 1'b1;
    @(negedge clk);
    checkOutput("tready_before_edge", 64'(tready0), 64'h0);
    @(negedge clk);
    checkOutput("tready_after_reset", 64'(tready0), 64'h1);
    @(posedge clk);
    #1;

    fork
      begin : dut0_seq
        applyStimulus(0, 16'hFFFF, 8'h01); measureBusy(0, n, idle_n);
        checkOutput("t1_len", 64'(n), 64'd2000);
        applyStimulus(0, 16'h0000, 8'h00); measureBusy(0, n, idle_n);
        checkOutput("t2_len", 64'(n), 64'd2000);
        applyStimulus(0, 16'h0001, 8'h03); measureBusy(0, n, idle_n);
        applyStimulus(0, 16'hA5A5, 8'h59); measureBusy(0, n, idle_n);
        applyStimulus(0, 16'hA5A5, 8'h05); measureBusy(0, n, idle_n);
        @(posedge clk); #1;
        applyStimulus(0, 16'h1357, 8'h01);
        fork
          applyStimulus(0, 16'h2468, 8'h00);
          measureBusy(0, n, idle_n);
        join
        checkOutput("t5_b2b_len", 64'(n), 64'd4000);
        @(posedge clk); #1;
        applyStimulus(0, 16'h1234, 8'h01);
        repeat (699) @(posedge clk);
        #1;
        arstn0 = 1'b0;
        #1;
        checkOutput("t6_diff_in_reset",   64'(diff0),   64'(IDLE0));
        checkOutput("t6_tready_in_reset", 64'(tready0), 64'h0);
        @(posedge clk); #1;
        arstn0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_tready_release", 64'(tready0), 64'h1);
        @(posedge clk); #1;
        applyStimulus(0, 16'hBEEF, 8'h00); measureBusy(0, n, idle_n);
        checkOutput("t6_len", 64'(n), 64'd2000);
        @(posedge clk); #1;
        for (int w = 0; w < 8; w++) begin
          applyStimulus(0, 16'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        measureBusy(0, n, idle_n);
      end
      begin : dut1_seq
        applyStimulus(1, 16'hC3C3, 8'h00); measureBusy(1, n, idle_n);
        checkOutput("g_len", 64'(n), 64'd2400);
        checkOutput("g_gap_idle", 64'(idle_n), 64'd400);
        @(posedge clk); #1;
        for (int w = 0; w < 8; w++) begin
          applyStimulus(1, 16'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        measureBusy(1, n, idle_n);
      end
    join

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
